// File: rtl/program_memory.sv
// Instruction store with 1-cycle registered fetch and a byte-serial loader (MSB first).
// Loader words beyond DEPTH or truncated by load_done are dropped and flagged in load_error.
module program_memory #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic                  instruction_valid,
  input  logic                  load_start,
  input  logic                  load_byte_valid,
  input  logic [7:0]            load_byte,
  input  logic                  load_done,
  output logic                  loading,
  output logic [ADDR_WIDTH:0]   load_count,
  output logic                  load_error
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BYTES - 1);

  typedef enum logic {RUN, LOAD} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] asm_q, asm_d;
  logic [BCW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  ivld_q;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] word_next;
  logic                  in_range;

  // Contents survive reset; only configuration/simulation start zeroes them.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  // The load counter doubles as the write pointer: both restart at 0 and advance together.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    asm_d     = asm_q;
    bcnt_d    = bcnt_q;
    wr_en     = 1'b0;
    word_next = (asm_q << 8) | DATA_WIDTH'(load_byte);
    if (load_start) begin
      state_d = LOAD;
      cnt_d   = '0;
      err_d   = 1'b0;
      asm_d   = '0;
      bcnt_d  = '0;
    end else if (state_q == LOAD) begin
      if (load_byte_valid) begin
        if (bcnt_q == LAST_BYTE) begin
          bcnt_d = '0;
          asm_d  = '0;
          if (cnt_q == DEPTH_W) begin
            err_d = 1'b1;
          end else begin
            wr_en = !reset;
            cnt_d = cnt_q + (ADDR_WIDTH+1)'(1);
          end
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
          asm_d  = word_next;
        end
      end
      // load_done is judged after this cycle's byte has been taken.
      if (load_done) begin
        state_d = RUN;
        if (bcnt_d != '0) err_d = 1'b1;
        bcnt_d = '0;
        asm_d  = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[cnt_q[IDXW-1:0]] <= word_next;
  end

  assign in_range = {1'b0, fetch_addr} < DEPTH_W;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      asm_q   <= '0;
      bcnt_q  <= '0;
      instr_q <= '0;
      ivld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      asm_q   <= asm_d;
      bcnt_q  <= bcnt_d;
      if (fetch_en && state_q == RUN) begin
        instr_q <= in_range ? mem_q[fetch_addr[IDXW-1:0]] : '0;
        ivld_q  <= 1'b1;
      end else begin
        ivld_q  <= 1'b0;
      end
    end
  end

  assign instruction       = instr_q;
  assign instruction_valid = ivld_q;
  assign loading           = (state_q == LOAD);
  assign load_count        = cnt_q;
  assign load_error        = err_q;

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning fetch/load address width.
REQ-002 SHALL have parameter DEPTH, default 256, meaning number of instruction words stored; legal range 1..2^ADDR_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning instruction word width; legal values are multiples of 8, with BYTES = DATA_WIDTH/8.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port: clock, input, 1, sole clock; all logic on rising edge.
REQ-006 SHALL have port: reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port: fetch_en, input, 1, fetch request for fetch_addr this cycle.
REQ-008 SHALL have port: fetch_addr, input, ADDR_WIDTH, word address to fetch.
REQ-009 SHALL have port: instruction, output, DATA_WIDTH, registered fetched word.
REQ-010 SHALL have port: instruction_valid, output, 1, instruction updated by a fetch in the previous cycle.
REQ-011 SHALL have port: load_start, input, 1, opens a load session at word address 0.
REQ-012 SHALL have port: load_byte_valid, input, 1, load_byte is valid this cycle.
REQ-013 SHALL have port: load_byte, input, 8, program byte.
REQ-014 SHALL have port: load_done, input, 1, closes the load session.
REQ-015 SHALL have port: loading, output, 1, high while in the LOAD state.
REQ-016 SHALL have port: load_count, output, ADDR_WIDTH+1, words written in the current or last session.
REQ-017 SHALL have port: load_error, output, 1, sticky session error flag.

Function
REQ-018 SHALL implement two states: RUN and LOAD; RUN goes to LOAD on load_start; LOAD goes to RUN on load_done.
REQ-019 SHALL, in RUN with fetch_en=1, drive instruction=mem[fetch_addr] and instruction_valid=1 on the next cycle (1-cycle latency).
REQ-020 SHALL, with fetch_en=0 or in LOAD, hold instruction at its previous value and drive instruction_valid=0 next cycle.
REQ-021 SHALL return 0 (NOP) for any fetch with fetch_addr >= DEPTH.
REQ-022 SHALL initialise all memory words to 0 at configuration/simulation start.
REQ-023 SHALL assemble bytes in LOAD most-significant byte first; the BYTES-th accepted byte writes the completed word at the load pointer and increments both the pointer and load_count.
REQ-024 SHALL ignore load_byte_valid in RUN.
REQ-025 SHALL, when a byte completes a word while load_count == DEPTH, discard that word and set load_error.
REQ-026 SHALL, on load_start (in any state), set the pointer and load_count to 0, clear the byte assembler and load_error, and enter LOAD; a load_byte_valid in the same cycle is discarded.
REQ-027 SHALL, when load_byte_valid and load_done occur in the same cycle, accept the byte first and then evaluate load_done.
REQ-028 SHALL, on load_done with a partially assembled word, discard the partial word and set load_error.
REQ-029 SHALL give load_start priority over load_done when both are asserted in the same cycle.
REQ-030 SHALL hold load_count and load_error in RUN until the next load_start.

Reset
REQ-031 SHALL, on reset, set: state RUN, instruction 0, instruction_valid 0, loading 0, load_count 0, load_error 0, pointer and assembler cleared.
REQ-032 SHALL, on reset in mid-load, discard any partial word; words already written SHALL be retained; memory is never cleared by reset.

Verification
REQ-033 SHALL pass this scenario: after reset, fetch_en=1, addr 5 -> next cycle instruction=0x00000000, instruction_valid=1.
REQ-034 SHALL pass this scenario: load_start, bytes 12 34 56 78 AB CD EF 01, load_done, then fetch addr 0 and 1 -> 0x12345678 then 0xABCDEF01; load_count=2, load_error=0.
REQ-035 SHALL pass this scenario: with DEPTH=4, load 5 words -> load_count=4, load_error=1, fetch addr 3 returns the 4th word.
REQ-036 SHALL pass this scenario: load 6 bytes, then load_done -> load_count=1, load_error=1, word 1 unchanged.
REQ-037 SHALL pass this scenario: fetch_en=1 during LOAD -> instruction_valid=0 and instruction held; last byte together with load_done in the same cycle completes the word, load_count increments, and the block returns to RUN.
REQ-038 SHALL pass this scenario: reset after 2 bytes of word 3 -> loading=0, load_count=0, words 0..2 still fetch their loaded values.
